// File: rtl/aes_pkg.sv
// Shared AES helpers: S-box table, stage FSM states, byte addressing and ShiftRows.
// Pure functions and constants; no latency of their own.
// No flow control here; callers handle handshakes.
//
// Byte i of a 128-bit state lives at bits [127-8i -: 8] and is column-major:
// row = i % 4, column = i / 4.
package aes_pkg;

    localparam int BLOCK_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [7:0] SBOX_TABLE [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[b];
    endfunction

    function automatic logic [3:0] byte_idx(input int row, input int col);
        return 4'(4 * col + row);
    endfunction

    function automatic logic [7:0] get_byte(input logic [127:0] s, input logic [3:0] i);
        return s[8 * (4'd15 - i) +: 8];
    endfunction

    function automatic logic [127:0] put_byte(input logic [127:0] s, input logic [3:0] i,
                                              input logic [7:0] b);
        logic [127:0] r;
        r = s;
        r[8 * (4'd15 - i) +: 8] = b;
        return r;
    endfunction

    // Row r is rotated left by r positions: out(r, c) = in(r, (c + r) % 4).
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r_out;
        r_out = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                r_out = put_byte(r_out, byte_idx(r, c), get_byte(s, byte_idx(r, (c + r) % 4)));
            end
        end
        return r_out;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single AES S-box lane: one byte in, one substituted byte out.
// Combinational, zero cycles.
// No flow control.
//
// Ports: in_byte (8) -> out_byte (8).
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    assign out_byte = sbox(in_byte);

endmodule

// File: rtl/sub_shift_stage.sv
// Registered SubBytes + ShiftRows stage of an AES encryption round.
// Latency 16/SBOX_LANES cycles from capture to OUT_VALID; one block per 16/SBOX_LANES+1 cycles.
// OUT_READY low holds the finished block in DONE; IN_READY is low until it drains.
//
// Ports: CLK, RST_N (async active-low); IN_VALID/IN_READY/IN (128b input state);
//        OUT_VALID/OUT_READY/OUT (128b ShiftRows-permuted result, zero unless valid);
//        BUSY (block in flight). BLK_COUNT (32b output handshake count) exists only
//        when SUB_SHIFT_PERF_CNT_EN is defined.
// BLOCK_LENGTH must be 128; SBOX_LANES must be 1, 2, 4, 8 or 16.
module sub_shift_stage
    import aes_pkg::*;
#(
    parameter int BLOCK_LENGTH = 128,
    parameter int SBOX_LANES   = 4
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic [BLOCK_LENGTH-1:0] IN,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic [BLOCK_LENGTH-1:0] OUT,
    output logic                    BUSY
`ifdef SUB_SHIFT_PERF_CNT_EN
    ,
    output logic [31:0]             BLK_COUNT
`endif
);

    localparam int               GROUPS   = BLOCK_BYTES / SBOX_LANES;
    localparam int               CNT_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GROUPS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [127:0]     buf_q, buf_d;

    // First byte index of the group being substituted this cycle.
    logic [3:0]       grp_base;
    logic [7:0]       lane_in  [SBOX_LANES];
    logic [7:0]       lane_out [SBOX_LANES];

    assign grp_base = 4'(int'(cnt_q) * SBOX_LANES);

    for (genvar l = 0; l < SBOX_LANES; l++) begin : g_lane
        assign lane_in[l] = get_byte(buf_q, grp_base + 4'(l));
        aes_sbox u_sbox (
            .in_byte  (lane_in[l]),
            .out_byte (lane_out[l])
        );
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;
        case (state_q)
            IDLE: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    buf_d   = IN;
                    cnt_d   = '0;
                    state_d = SUB;
                end
            end
            SUB: begin
                for (int l = 0; l < SBOX_LANES; l++) begin
                    buf_d = put_byte(buf_d, grp_base + 4'(l), lane_out[l]);
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                OUT_VALID = 1'b1;
                // The result sits in buf_q, so the slot frees up in the same
                // cycle the downstream takes it.
                IN_READY  = OUT_READY;
                if (OUT_READY) begin
                    if (IN_VALID) begin
                        buf_d   = IN;
                        cnt_d   = '0;
                        state_d = SUB;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    assign OUT  = OUT_VALID ? shift_rows(buf_q) : '0;
    assign BUSY = (state_q == SUB) || (state_q == DONE);

`ifdef SUB_SHIFT_PERF_CNT_EN
    logic [31:0] blk_count_q, blk_count_d;

    always_comb begin
        blk_count_d = blk_count_q;
        if (OUT_VALID && OUT_READY) begin
            blk_count_d = blk_count_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            blk_count_q <= '0;
        end else begin
            blk_count_q <= blk_count_d;
        end
    end

    assign BLK_COUNT = blk_count_q;
`endif

endmodule
